// File: rtl/instr_mem_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_pkg
// Shared definitions for the instruction memory: the default halt/fill word
// and the controller state encoding.
// ---------------------------------------------------------------------------
package instr_mem_pkg;

    // Word written by the fill sequence and returned for faulting fetches.
    localparam logic [15:0] HALT_WORD_DEFAULT = 16'hEBCF;

    // Controller states: INIT fills the array, READY serves fetches and loads.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

endpackage : instr_mem_pkg

// File: rtl/instr_mem_array.sv
// ---------------------------------------------------------------------------
// instr_mem_array
// DEPTH x DATA_W storage with one write port and one registered read port.
// A read and a write to the same index in one cycle return the old word.
//
// Ports
//   clk      rising-edge clock
//   we_i     write enable
//   waddr_i  write word index
//   wdata_i  write data
//   re_i     read enable; rdata_o updates only when set
//   raddr_i  read word index
//   rdata_o  read data, one cycle after re_i, held otherwise
// ---------------------------------------------------------------------------
module instr_mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage write and registered read; the read samples the pre-write word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : instr_mem_array

// File: rtl/instr_mem.sv
// ---------------------------------------------------------------------------
// instr_mem
// Instruction memory with a power-up fill sequence, a single-cycle-latency
// fetch port and a program-load write port. Fetches that are misaligned or
// beyond the array return HALT_WORD flagged with addr_err.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; restarts the fill
//   fetch_req    fetch request, accepted when fetch_ready is high
//   fetch_addr   fetch byte address
//   fetch_ready  high in READY
//   instr_valid  one-cycle pulse, the cycle after an accepted fetch
//   instr        fetched word, held while instr_valid is low
//   addr_err     with instr_valid: fetch was misaligned or out of range
//   prog_we      load write enable (ignored during the fill)
//   prog_addr    load byte address
//   prog_data    load data
//   init_busy    high while the fill sequence runs
// ---------------------------------------------------------------------------
module instr_mem
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                DEPTH     = 32,
    parameter int                ADDR_W    = 8,
    parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(HALT_WORD_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic              addr_err,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              init_busy
);

    localparam int                BYTES     = DATA_W / 8;
    localparam int                OFF_W     = $clog2(BYTES);
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

    // True when a byte address is word aligned and its index lies in the array.
    // Indices past the end are errors; they never alias onto low entries.
    function automatic logic addr_in_map(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] idx;
        idx = a >> OFF_W;
        return ((a & OFF_MASK) == '0) && ({1'b0, idx} < DEPTH_EXT);
    endfunction

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              valid_q;
    logic              err_q;
    logic              halt_sel_q;   // selects HALT_WORD onto instr

    logic              f_ok_s;
    logic              accept_s;
    logic [IDX_W-1:0]  f_idx_s;
    logic [IDX_W-1:0]  p_idx_s;
    logic              we_s;
    logic              arr_we_s;
    logic [IDX_W-1:0]  waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] rdata_s;

    assign f_ok_s   = addr_in_map(fetch_addr);
    assign f_idx_s  = IDX_W'(fetch_addr >> OFF_W);
    assign p_idx_s  = IDX_W'(prog_addr >> OFF_W);
    assign accept_s = fetch_req && (state_q == READY) && !rst;
    // No array writes of any kind while reset is asserted.
    assign arr_we_s = we_s && !rst;

    // Next-state, fill counter and write-port steering.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_s    = 1'b0;
        waddr_s = cnt_q;
        wdata_s = HALT_WORD;
        case (state_q)
            INIT: begin
                we_s    = 1'b1;
                waddr_s = cnt_q;
                wdata_s = HALT_WORD;
                if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            READY: begin
                if (prog_we && addr_in_map(prog_addr)) begin
                    we_s    = 1'b1;
                    waddr_s = p_idx_s;
                    wdata_s = prog_data;
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Controller state and fetch response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            halt_sel_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= accept_s;
            if (accept_s) begin
                err_q      <= !f_ok_s;
                halt_sel_q <= !f_ok_s;
            end else begin
                err_q <= 1'b0;
            end
        end
    end

    instr_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we_s),
        .waddr_i (waddr_s),
        .wdata_i (wdata_s),
        .re_i    (accept_s && f_ok_s),
        .raddr_i (f_idx_s),
        .rdata_o (rdata_s)
    );

    // The array only reads on good fetches, so its held output stays valid
    // for instr-hold; faults and reset substitute HALT_WORD instead.
    assign instr       = halt_sel_q ? HALT_WORD : rdata_s;
    assign instr_valid = valid_q;
    assign addr_err    = err_q;
    assign fetch_ready = (state_q == READY);
    assign init_busy   = (state_q == INIT);

endmodule : instr_mem
